// File: rtl/dash_display_scanner.sv
// dash_display_scanner
//   Upstream driver for the dashboard 7-segment stage. A binary reading is
//   captured on a load strobe, converted to BCD by a sequential double-dabble
//   (one bit per clk), committed atomically to an 8-digit display register and
//   time-multiplexed out as a digit/pos pair at the refresh rate.
//
// Parameters
//   BIN_W        width of the binary input (4..27)
//   REFRESH_DIV  clk cycles each digit position is held (>= 2)
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   value  in   [BIN_W-1:0] binary value, sampled when load=1
//   load   in   1-cycle load strobe; while busy it queues a 1-deep pending value
//   busy   out  conversion in progress (SHIFT or COMMIT)
//   done   out  1-cycle pulse in the cycle the new BCD value is committed
//   digit  out  [3:0] BCD digit for the current position (0..9)
//   pos    out  [3:0] current position 1..8, 1 = least significant
//
// Build option
//   DASH_DISPLAY_SATURATE_EN  when defined, values above 99,999,999 commit as
//                             all nines; otherwise the ninth digit is dropped.
module dash_display_scanner #(
  parameter int BIN_W       = 27,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [3:0]       digit,
  output logic [3:0]       pos
);

  localparam int             PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [4:0]     BITS       = 5'(BIN_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [35:0] dabble_adj(input logic [35:0] b);
    logic [35:0] r;
    r = b;
    for (int i = 0; i < 9; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = b[i*4 +: 4];
      end
    end
    return r;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [BIN_W-1:0] shift_r, shift_nxt_s;
  logic [35:0]      bcd_r, bcd_nxt_s, adj_s;
  logic [4:0]       cnt_r, cnt_nxt_s;
  logic             pend_r, pend_nxt_s;
  logic [BIN_W-1:0] pend_val_r, pend_val_nxt_s;
  logic [31:0]      disp_r, disp_nxt_s, commit_val_s, digit_src_s;
  logic             busy_r, done_r, done_nxt_s;
  logic [PW-1:0]    presc_r;
  logic [3:0]       pos_r, digit_r;
  logic [2:0]       idx_s;

  // Value that COMMIT writes into the display register.
`ifdef DASH_DISPLAY_SATURATE_EN
  assign commit_val_s = (bcd_r[35:32] != 4'd0) ? 32'h9999_9999 : bcd_r[31:0];
`else
  assign commit_val_s = bcd_r[31:0];
`endif

  // Converter next-state and datapath.
  always_comb begin
    state_nxt_s    = state_r;
    shift_nxt_s    = shift_r;
    bcd_nxt_s      = bcd_r;
    cnt_nxt_s      = cnt_r;
    pend_nxt_s     = pend_r;
    pend_val_nxt_s = pend_val_r;
    disp_nxt_s     = disp_r;
    done_nxt_s     = 1'b0;
    adj_s          = dabble_adj(bcd_r);
    case (state_r)
      IDLE: begin
        if (load) begin
          shift_nxt_s = value;
          bcd_nxt_s   = 36'd0;
          cnt_nxt_s   = BITS;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        bcd_nxt_s   = {adj_s[34:0], shift_r[BIN_W-1]};
        shift_nxt_s = {shift_r[BIN_W-2:0], 1'b0};
        cnt_nxt_s   = cnt_r - 5'd1;
        if (load) begin
          pend_nxt_s     = 1'b1;
          pend_val_nxt_s = value;
        end else begin
          pend_nxt_s     = pend_r;
        end
        if (cnt_r == 5'd1) begin
          state_nxt_s = COMMIT;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      COMMIT: begin
        disp_nxt_s = commit_val_s;
        // A load landing in COMMIT itself is newer than any pending value.
        if (load) begin
          shift_nxt_s = value;
          bcd_nxt_s   = 36'd0;
          cnt_nxt_s   = BITS;
          pend_nxt_s  = 1'b0;
          state_nxt_s = SHIFT;
        end else if (pend_r) begin
          shift_nxt_s = pend_val_r;
          bcd_nxt_s   = 36'd0;
          cnt_nxt_s   = BITS;
          pend_nxt_s  = 1'b0;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Converter state, datapath and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      bcd_r      <= 36'd0;
      cnt_r      <= 5'd0;
      pend_r     <= 1'b0;
      pend_val_r <= '0;
      disp_r     <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      shift_r    <= shift_nxt_s;
      bcd_r      <= bcd_nxt_s;
      cnt_r      <= cnt_nxt_s;
      pend_r     <= pend_nxt_s;
      pend_val_r <= pend_val_nxt_s;
      disp_r     <= disp_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
      done_r     <= done_nxt_s;
    end
  end

  // Digit source bypasses the display register during COMMIT so the digit
  // output shows the new value on the cycle right after COMMIT.
  always_comb begin
    idx_s       = pos_r[2:0] - 3'd1;
    digit_src_s = (state_r == COMMIT) ? commit_val_s : disp_r;
  end

  // Free-running scanner: prescaler, position and registered digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r <= '0;
      pos_r   <= 4'd1;
      digit_r <= 4'd0;
    end else begin
      if (presc_r == PRESC_LAST) begin
        presc_r <= '0;
        pos_r   <= (pos_r == 4'd8) ? 4'd1 : (pos_r + 4'd1);
      end else begin
        presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
        pos_r   <= pos_r;
      end
      digit_r <= digit_src_s[idx_s*4 +: 4];
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign digit = digit_r;
  assign pos   = pos_r;

endmodule

// File: tb/tb_dash_display_scanner.sv
module tb_dash_display_scanner;

  logic        clk;
  logic        rst_n;
  logic [26:0] value;
  logic        load;
  logic        busy;
  logic        done;
  logic [3:0]  digit;
  logic [3:0]  pos;

  int checks = 0;
  int errors = 0;

  dash_display_scanner #(.BIN_W(27), .REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .digit (digit),
    .pos   (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] val;
    logic [31:0] bcd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [31:0] b, input logic [3:0] p);
    logic [3:0] r;
    if (p == 4'd0 || p > 4'd8) r = 4'hF;
    else r = b[(int'(p) - 1) * 4 +: 4];
    return r;
  endfunction

  // Observe ~one full frame and rebuild the display from stable samples.
  task automatic read_frame(input string name, input logic [31:0] exp);
    logic [31:0] got;
    logic [7:0]  seen;
    logic [3:0]  prev_pos;
    int bad;
    got = 32'd0; seen = 8'd0; bad = 0;
    prev_pos = pos;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pos == prev_pos && pos >= 4'd1 && pos <= 4'd8) begin
        got[(int'(pos) - 1) * 4 +: 4] = digit;
        seen[int'(pos) - 1] = 1'b1;
      end
      if (digit > 4'd9 || done !== 1'b0 || busy !== 1'b0) bad++;
      prev_pos = pos;
    end
    chk({name, "_frame"}, got, exp);
    chk({name, "_seen"}, {24'd0, seen}, 32'h0000_00FF);
    chk({name, "_quiet"}, bad, 32'd0);
  endtask

  // Load v0 at cycle 0 (plus optional loads at c2/c3), run until n_done
  // done pulses, checking busy, digit stability and commit timing.
  task automatic run_conv(input string name, input logic [26:0] v0,
                          input int c2, input logic [26:0] v2,
                          input int c3, input logic [26:0] v3,
                          input logic [31:0] old_exp, input logic [31:0] new1,
                          input logic [31:0] new2, input int n_done,
                          output int d1, output int d2);
    int nd, bad_busy, bad_dig, bad_rng;
    logic [3:0]  prev_pos, p_at;
    logic [31:0] cur, fin;
    d1 = -1; d2 = -1; nd = 0; bad_busy = 0; bad_dig = 0; bad_rng = 0;
    prev_pos = pos; p_at = 4'd1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (busy !== 1'b0) bad_busy++;
      end else begin
        if (busy !== 1'b1) bad_busy++;
        cur = (nd == 0) ? old_exp : ((nd == 1) ? new1 : new2);
        if (pos == prev_pos && digit !== nib(cur, pos)) bad_dig++;
        if (digit > 4'd9) bad_rng++;
        if (done === 1'b1) begin
          nd++;
          if (nd == 1) d1 = c;
          else d2 = c;
          p_at = pos;
        end
      end
      prev_pos = pos;
      if (c == 0) begin
        value = v0; load = 1'b1;
      end else if (c == c2) begin
        value = v2; load = 1'b1;
      end else if (c == c3) begin
        value = v3; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if (nd == n_done) break;
    end
    load = 1'b0;
    if (nd != n_done) $display("FAIL %s_timeout actual=%0d required=%0d", name, nd, n_done);
    fin = (n_done == 1) ? new1 : new2;
    @(negedge clk);
    chk({name, "_busy_held"}, bad_busy, 32'd0);
    chk({name, "_digit_stable"}, bad_dig, 32'd0);
    chk({name, "_digit_range"}, bad_rng, 32'd0);
    chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({name, "_done_after"}, {31'd0, done}, 32'd0);
    chk({name, "_digit_after_commit"}, {28'd0, digit}, {28'd0, nib(fin, p_at)});
  endtask

  initial begin
    vec_t vecs[8];
    logic [31:0] last;
    logic [3:0]  prev_pos, exp_pos;
    int d1, d2, run, trans, bad;

    vecs[0] = '{27'd12345678,  32'h1234_5678};
`ifdef DASH_DISPLAY_SATURATE_EN
    vecs[1] = '{27'd123456789, 32'h9999_9999};
    vecs[5] = '{27'd134217727, 32'h9999_9999};
`else
    vecs[1] = '{27'd123456789, 32'h2345_6789};
    vecs[5] = '{27'd134217727, 32'h3421_7727};
`endif
    vecs[2] = '{27'd99999999,  32'h9999_9999};
    vecs[3] = '{27'd0,         32'h0000_0000};
    vecs[4] = '{27'd9,         32'h0000_0009};
    vecs[6] = '{27'd10,        32'h0000_0010};
    vecs[7] = '{27'd90817,     32'h0009_0817};

    rst_n = 1'b0; load = 1'b0; value = 27'd0;
    repeat (3) @(negedge clk);
    chk("reset_pos",   {28'd0, pos},   32'd1);
    chk("reset_digit", {28'd0, digit}, 32'd0);
    chk("reset_busy",  {31'd0, busy},  32'd0);
    chk("reset_done",  {31'd0, done},  32'd0);
    rst_n = 1'b1;

    // Scan order and hold length with a blank display.
    prev_pos = pos; run = 1; trans = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pos == prev_pos) begin
        run++;
      end else begin
        exp_pos = (prev_pos == 4'd8) ? 4'd1 : prev_pos + 4'd1;
        if (run != 4 || pos != exp_pos) bad++;
        trans++;
        run = 1;
      end
      if (pos < 4'd1 || pos > 4'd8 || digit !== 4'd0) bad++;
      prev_pos = pos;
    end
    chk("scan_order_hold", bad, 32'd0);
    chk("scan_transitions", trans, 32'd10);

    // Table of single conversions.
    last = 32'd0;
    for (int i = 0; i < 8; i++) begin
      run_conv($sformatf("vec%0d", i), vecs[i].val, -1, 27'd0, -1, 27'd0,
               last, vecs[i].bcd, 32'd0, 1, d1, d2);
      chk($sformatf("vec%0d_done_cycle", i), d1, 32'd28);
      read_frame($sformatf("vec%0d", i), vecs[i].bcd);
      last = vecs[i].bcd;
    end

    // Loads while busy: last pending value wins, busy never drops.
    run_conv("pend", 27'd250, 5, 27'd77, 10, 27'd99,
             last, 32'h0000_0250, 32'h0000_0099, 2, d1, d2);
    chk("pend_done1_cycle", d1, 32'd28);
    chk("pend_done2_cycle", d2, 32'd56);
    read_frame("pend", 32'h0000_0099);

    // Reset in the middle of a conversion.
    @(negedge clk);
    value = 27'd4321; load = 1'b1;
    bad = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (done !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("midreset_pre", bad, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_busy",  {31'd0, busy},  32'd0);
    chk("midreset_done",  {31'd0, done},  32'd0);
    chk("midreset_pos",   {28'd0, pos},   32'd1);
    chk("midreset_digit", {28'd0, digit}, 32'd0);
    read_frame("midreset", 32'd0);
    run_conv("after_reset", 27'd4321, -1, 27'd0, -1, 27'd0,
             32'd0, 32'h0000_4321, 32'd0, 1, d1, d2);
    chk("after_reset_done_cycle", d1, 32'd28);
    read_frame("after_reset", 32'h0000_4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dash_display_scanner.md
Name: dash_display_scanner

Overview:
- Upstream driver for the dashboard 7-segment stage. Accepts a binary reading, such as speed or odometer, on a load strobe.
- Converts the reading to 8 BCD digits using a sequential double-dabble converter, one bit per cycle.
- Time-multiplexes the digits by presenting a digit[3:0]/pos[3:0] pair that advances through positions 1..8 at the refresh rate.
- The outputs drive the segment decoder directly. That decoder is clocked from the same clk, and its inputs hold stable for REFRESH_DIV cycles.

Parameters:
- BIN_W, 27: width of the binary input. Legal range 4..27.
- REFRESH_DIV, 100000: clk cycles per digit position. 100 MHz gives 1 kHz per digit and 125 Hz full frame. Must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  synchronous active-low reset
- value  input  BIN_W  binary value to display
- load  input  1  1-cycle strobe; value is sampled when load=1
- busy  output  1  conversion in progress
- done  output  1  1-cycle pulse when the new BCD value is committed to the display
- digit  output  4  BCD digit for the current position, 0..9 only
- pos  output  4  current position, 1..8; 1 is the rightmost, least-significant digit

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - pos=1, digit=0, busy=0, done=0
  - display register all zeros, shift/BCD registers zero, pending flag clear, prescaler 0
- Reset applies in any state, including mid-conversion. Any in-flight or pending conversion is discarded.

Converter FSM, states IDLE, SHIFT, COMMIT:
- IDLE:
  - If load=1: capture value into the shift register, clear the BCD accumulator, load bit counter = BIN_W, go to SHIFT.
  - busy rises the cycle after load.
- SHIFT, one bit per cycle:
  - Each BCD nibble ≥ 5 gets +3.
  - Then the {BCD, shift} register shifts left 1.
  - The bit counter decrements. After BIN_W shifts, go to COMMIT.
- COMMIT, one cycle:
  - Copy the BCD accumulator to the display register.
  - done=1 for this cycle.
  - If the pending flag is set: clear it, restart with the pending value and go to SHIFT, keeping busy=1.
  - Otherwise go to IDLE, busy=0 next cycle.
- Latency: load sampled at cycle 0, SHIFT spans cycles 1..BIN_W, COMMIT and done at cycle BIN_W+1.
- The BCD accumulator is 9 digits (36 bits), so 2^27−1 = 134,217,727 fits.
- Load while busy (SHIFT or COMMIT):
  - The value is stored in a 1-deep pending register and the pending flag is set.
  - A later load before the restart overwrites the pending value; the last one wins.
- The display register changes only in COMMIT. It never shows a partial conversion.

Scanner:
- The prescaler runs freely, counting 0..REFRESH_DIV−1 and wrapping.
- At terminal count, pos advances 1→2→…→8→1.
- digit is registered: each cycle it takes display nibble [pos−1], where pos is the pos register value that same cycle.
- Consequences:
  - digit lags a pos change by one clk.
  - digit reflects a new commit on the cycle after COMMIT.
- pos never takes the values 0 or 9..15.
- The scanner is independent of the converter FSM; conversion never stalls the scan.

Optional Feature:
- Macro: DASH_DISPLAY_SATURATE_EN.
- Defined:
  - If the converted value exceeds 99,999,999 (ninth BCD digit nonzero), commit all-nines (0x99999999).
  - done still pulses.
- Undefined:
  - Commit the lower 8 BCD digits and drop the ninth, so the display shows value mod 100,000,000.
- Feature on or off, conversion latency is identical.

Test Plan:
All scenarios use BIN_W=27 and REFRESH_DIV=4.
1. Reset → pos=1, digit=0, busy=0, done=0. Scan is 1,2,…,8,1 with each position held exactly 4 cycles. All digits are 0.
2. load with value=12345678 → busy high cycles 1..28, done at cycle 28. One full frame then reads pos1..8 = 8,7,6,5,4,3,2,1.
3. load 250, then load 77 at cycle 5, then load 99 at cycle 10:
   - First done shows 250.
   - Conversion restarts without busy dropping.
   - Second done, 28 cycles later, shows 99; 77 is never displayed.
4. value=123456789 (0x75BCD15):
   - Macro undefined: display reads 23456789.
   - Macro defined: display reads 99999999.
   - Also value=99999999 → display 99999999 in both builds.
5. Drop rst_n at cycle 15 of a conversion of 4321:
   - busy=0 and display is all zeros after the edge.
   - No done pulse occurs.
   - pos=1; the next load converts correctly.
6. value=0 and value=134217727:
   - 0 → all zeros.
   - 134217727, unsaturated → 34217727.
   - digit is never >9 at any sample.
